// File: rtl/decode_stage.sv
// RV32I decode: splits register fields, builds the immediate and a one-hot class vector.
// Latency 1 cycle (accept in n, visible in n+1); a one-entry skid buffer keeps full throughput.
// o_ready falls only while the skid entry is occupied; a held bundle stays stable until taken.
module decode_stage #(
  parameter int N_param = 32,
  parameter int CNT_W   = 16
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_en,
  input  logic               i_flush,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [N_param-1:0] i_instruction,
  input  logic [N_param-1:0] i_pc,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [4:0]         o_rd,
  output logic [4:0]         o_rs1,
  output logic [4:0]         o_rs2,
  output logic [2:0]         o_fun3,
  output logic [6:0]         o_fun7,
  output logic [N_param-1:0] o_imm,
  output logic [63:0]        o_Single_Instruction,
  output logic [N_param-1:0] o_pc,
  output logic [CNT_W-1:0]   o_unknown_count
);

  typedef struct packed {
    logic [4:0]         rd;
    logic [4:0]         rs1;
    logic [4:0]         rs2;
    logic [2:0]         fun3;
    logic [6:0]         fun7;
    logic [N_param-1:0] imm;
    logic [63:0]        cls;
    logic [N_param-1:0] pc;
  } bundle_t;

  function automatic bundle_t decode(input logic [31:0] inst, input logic [31:0] pc);
    bundle_t     b;
    logic [5:0]  idx;
    logic [31:0] imm;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh, imm_csr;
    logic [6:0]  f7;
    logic [2:0]  f3;
    f7      = inst[31:25];
    f3      = inst[14:12];
    imm_i   = {{20{inst[31]}}, inst[31:20]};
    imm_s   = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    imm_b   = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    imm_u   = {inst[31:12], 12'b0};
    imm_j   = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    imm_sh  = {27'b0, inst[24:20]};
    imm_csr = {20'b0, inst[31:20]};
    idx     = 6'd0;
    imm     = '0;
    // Every legal opcode ends in 2'b11, so a bad inst[1:0] falls through to UNKNOWN.
    case (inst[6:0])
      7'b0110011: begin
        case ({f7, f3})
          {7'h00, 3'b000}: idx = 6'd1;
          {7'h20, 3'b000}: idx = 6'd2;
          {7'h00, 3'b100}: idx = 6'd3;
          {7'h00, 3'b110}: idx = 6'd4;
          {7'h00, 3'b111}: idx = 6'd5;
          {7'h00, 3'b001}: idx = 6'd6;
          {7'h00, 3'b101}: idx = 6'd7;
          {7'h20, 3'b101}: idx = 6'd8;
          {7'h00, 3'b010}: idx = 6'd9;
          {7'h00, 3'b011}: idx = 6'd10;
          default:         idx = 6'd0;
        endcase
      end
      7'b0010011: begin
        imm = imm_i;
        case (f3)
          3'b000:  idx = 6'd11;
          3'b100:  idx = 6'd12;
          3'b110:  idx = 6'd13;
          3'b111:  idx = 6'd14;
          3'b010:  idx = 6'd18;
          3'b011:  idx = 6'd19;
          3'b001: begin
            idx = (f7 == 7'h00) ? 6'd15 : 6'd0;
            imm = imm_sh;
          end
          default: begin
            idx = (f7 == 7'h00) ? 6'd16 : (f7 == 7'h20) ? 6'd17 : 6'd0;
            imm = imm_sh;
          end
        endcase
      end
      7'b0000011: begin
        imm = imm_i;
        case (f3)
          3'b000:  idx = 6'd20;
          3'b001:  idx = 6'd21;
          3'b010:  idx = 6'd22;
          3'b100:  idx = 6'd23;
          3'b101:  idx = 6'd24;
          default: idx = 6'd0;
        endcase
      end
      7'b0100011: begin
        imm = imm_s;
        case (f3)
          3'b000:  idx = 6'd25;
          3'b001:  idx = 6'd26;
          3'b010:  idx = 6'd27;
          default: idx = 6'd0;
        endcase
      end
      7'b1100011: begin
        imm = imm_b;
        case (f3)
          3'b000:  idx = 6'd28;
          3'b001:  idx = 6'd29;
          3'b100:  idx = 6'd30;
          3'b101:  idx = 6'd31;
          3'b110:  idx = 6'd32;
          3'b111:  idx = 6'd33;
          default: idx = 6'd0;
        endcase
      end
      7'b1101111: begin idx = 6'd34; imm = imm_j; end
      7'b1100111: begin idx = (f3 == 3'b000) ? 6'd35 : 6'd0; imm = imm_i; end
      7'b0110111: begin idx = 6'd36; imm = imm_u; end
      7'b0010111: begin idx = 6'd37; imm = imm_u; end
      7'b1110011: begin
        imm = imm_csr;
        case (f3)
          3'b000: begin
            imm = '0;
            idx = (inst == 32'h0000_0073) ? 6'd38 :
                  (inst == 32'h0010_0073) ? 6'd39 : 6'd0;
          end
          3'b001:  idx = 6'd42;
          3'b010:  idx = 6'd43;
          3'b011:  idx = 6'd44;
          3'b101:  idx = 6'd45;
          3'b110:  idx = 6'd46;
          3'b111:  idx = 6'd47;
          default: idx = 6'd0;
        endcase
      end
      7'b0001111: begin
        case (f3)
          3'b000:  idx = 6'd40;
          3'b001:  idx = 6'd41;
          default: idx = 6'd0;
        endcase
      end
      default: idx = 6'd0;
    endcase
    if (idx == 6'd0) imm = '0;
    b.rd   = inst[11:7];
    b.rs1  = inst[19:15];
    b.rs2  = inst[24:20];
    b.fun3 = f3;
    b.fun7 = f7;
    b.imm  = imm;
    b.cls  = 64'd1 << idx;
    b.pc   = pc;
    return b;
  endfunction

  bundle_t          m_dat, s_dat, new_dat;
  logic             m_vld, s_vld;
  logic             accept, fire;
  logic [CNT_W-1:0] unk_cnt;

  assign new_dat = decode(i_instruction, i_pc);
  assign o_valid = m_vld & i_en;
  assign o_ready = ~s_vld & i_en & ~i_rst;
  assign accept  = i_valid & o_ready;
  assign fire    = o_valid & i_ready;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      m_vld   <= 1'b0;
      s_vld   <= 1'b0;
      m_dat   <= '0;
      s_dat   <= '0;
      unk_cnt <= '0;
    end else begin
      // Counts every accepted UNKNOWN, including one discarded by a same-cycle flush.
      if (accept && new_dat.cls[0] && unk_cnt != '1)
        unk_cnt <= unk_cnt + CNT_W'(1);
      if (i_flush) begin
        m_vld <= 1'b0;
        s_vld <= 1'b0;
      end else if (i_en) begin
        if (fire && s_vld) begin
          m_dat <= s_dat;
          s_vld <= 1'b0;
        end else if (accept && (!m_vld || fire)) begin
          m_dat <= new_dat;
          m_vld <= 1'b1;
        end else if (accept) begin
          s_dat <= new_dat;
          s_vld <= 1'b1;
        end else if (fire) begin
          m_vld <= 1'b0;
        end
      end
    end
  end

  assign o_rd                 = m_dat.rd;
  assign o_rs1                = m_dat.rs1;
  assign o_rs2                = m_dat.rs2;
  assign o_fun3               = m_dat.fun3;
  assign o_fun7               = m_dat.fun7;
  assign o_imm                = m_dat.imm;
  assign o_Single_Instruction = m_dat.cls;
  assign o_pc                 = m_dat.pc;
  assign o_unknown_count      = unk_cnt;

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Pipelined RV32I decode stage, the producer of the field/one-hot bundle consumed by `execute`.
- Accepts 32-bit instruction words plus PC over a valid/ready handshake and splits out rd/rs1/rs2/fun3/fun7.
- Builds the sign-extended immediate per format and a 64-bit one-hot instruction class vector.
- Registered output with a one-entry skid buffer: full throughput under backpressure.

Parameters:
- N_param, 32, instruction/PC/immediate width; only 32 is supported.
- CNT_W, 16, width of the saturating unknown-instruction counter.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  reset, asynchronous, active-high.
- i_en  in  1  stage enable; 0 freezes all state.
- i_flush  in  1  synchronous flush, discards buffered instructions.
- i_valid  in  1  upstream word valid.
- o_ready  out  1  stage can accept a word.
- i_instruction  in  32  raw instruction word.
- i_pc  in  32  PC of that word.
- o_valid  out  1  decoded bundle valid.
- i_ready  in  1  execute accepts the bundle.
- o_rd / o_rs1 / o_rs2  out  5 each  inst[11:7] / inst[19:15] / inst[24:20], raw for every format.
- o_fun3  out  3  inst[14:12].
- o_fun7  out  7  inst[31:25].
- o_imm  out  32  decoded immediate.
- o_Single_Instruction  out  64  one-hot class vector.
- o_pc  out  32  PC carried with the bundle.
- o_unknown_count  out  CNT_W  count of accepted words decoded as UNKNOWN.

Behaviour:
- Class bit index follows this order: 0 UNKNOWN, 1 ADD, 2 SUB, 3 XOR, 4 OR, 5 AND, 6 SLL, 7 SRL, 8 SRA, 9 SLT, 10 SLTU, 11 ADDI, 12 XORI, 13 ORI, 14 ANDI, 15 SLLI, 16 SRLI, 17 SRAI, 18 SLTI, 19 SLTIU, 20 LB, 21 LH, 22 LW, 23 LBU, 24 LHU, 25 SB, 26 SH, 27 SW, 28 BEQ, 29 BNE, 30 BLT, 31 BGE, 32 BLTU, 33 BGEU, 34 JAL, 35 JALR, 36 LUI, 37 AUIPC, 38 ECALL, 39 EBREAK, 40 FENCE, 41 FENCEI, 42 CSRRW, 43 CSRRS, 44 CSRRC, 45 CSRRWI, 46 CSRRSI, 47 CSRRCI.
- Bits 63:48 are always 0. Exactly one bit is set whenever o_valid=1.
- UNKNOWN (bit 0) is selected when any of these hold:
  - inst[1:0] != 2'b11;
  - opcode is unlisted;
  - funct3/funct7 combination is unlisted;
  - SLLI/SRLI/SRAI has a bad fun7: only 0000000 is legal, plus 0100000 for SRAI;
  - SYSTEM word with fun3=000 is neither exactly 0x00000073 (ECALL) nor 0x00100073 (EBREAK).
- FENCE: opcode 0001111 with fun3=000. FENCEI: opcode 0001111 with fun3=001.
- Immediate rules:
  - I-type, loads, JALR: sext(inst[31:20]).
  - Shift-immediates: zero-extend inst[24:20].
  - S-type: sext{inst[31:25],inst[11:7]}.
  - B-type: sext{inst[31],inst[7],inst[30:25],inst[11:8],0}.
  - U-type: {inst[31:12],12'b0}.
  - J-type: sext{inst[31],inst[19:12],inst[20],inst[30:21],0}.
  - CSR*: zero-extend inst[31:20].
  - R-type, FENCE*, ECALL, EBREAK, UNKNOWN: 0.
- Storage: main register M (drives outputs) and skid register S, each with a valid bit. o_valid = M.valid & i_en.
- o_ready = ~S.valid & i_en & ~i_rst.
- accept = i_valid & o_ready. fire = o_valid & i_ready.
- Latency: a word accepted in cycle n appears on outputs in cycle n+1.
- Per-cycle update, in priority order:
  - i_rst: M.valid=S.valid=0, all outputs 0, o_unknown_count=0.
  - i_flush: M.valid=S.valid=0. Any same-cycle accept is discarded. The counter is still updated for that word.
  - i_en=0: no state change.
  - fire & S.valid: M<=S, S.valid<=0. No accept is possible in this case.
  - accept & (~M.valid | fire): M<=decode(new).
  - accept & M.valid & ~fire: S<=decode(new).
  - fire & ~accept: M.valid<=0.
- Ordering is strictly FIFO. A held bundle stays stable while o_valid=1 and i_ready=0.
- o_unknown_count increments on each accept whose decode is UNKNOWN and saturates at all-ones.
- Reset asserted mid-transfer drops both entries immediately. The first accept is possible in the first cycle after i_rst deasserts.

Test Plan:
- Reset, then i_ready=1 and push 0x002081B3 (add x3,x1,x2) at PC 0x100 -> next cycle o_valid=1, o_rd=3, o_rs1=1, o_rs2=2, o_Single_Instruction=0x2, o_imm=0, o_pc=0x100.
- Push 0xFFF00093 (addi x1,x0,-1), 0xFE000EE3 (beq x0,x0,-4), 0x123452B7 (lui x5,0x12345) back-to-back -> consecutive outputs:
  - vector 0x800, imm 0xFFFFFFFF;
  - vector 0x10000000, imm 0xFFFFFFFC;
  - vector 0x10_0000_0000, imm 0x12345000.
- i_ready=0 while pushing 3 words -> word1 held in M, word2 in S, o_ready=0, word3 stalls upstream. Raise i_ready -> words 1, 2, 3 emerge on three consecutive cycles, in order.
- Push 0x00000000, 0x40001013 (bad SLLI fun7), 0x00200073 -> each gives vector 0x1 and o_unknown_count=3. Preload count 0xFFFF and push another unknown -> count stays 0xFFFF.
- With M and S both full, assert i_flush with i_valid=1 -> next cycle o_valid=0, o_ready=1, no flushed or incoming bundle ever appears.
- Assert i_rst asynchronously mid-stream -> o_valid, o_Single_Instruction and o_unknown_count go to 0 without a clock edge. After release, a single push decodes normally.
